// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester (cpu/dbg) and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_done;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_done;
    logic [DW-1:0] rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, dbg_gnt, dbg_done, rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, dbg_gnt, dbg_done, rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer sharing one data memory between cpu and dbg.
module dmem_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW = 8,
    parameter int DW = 8
) (
    input logic clk,
    input logic reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3;

    logic [1:0] state_q, state_d, cnt_q, cnt_d;
    logic owner_q, owner_d, last_q, last_d, we_q, we_d;
    logic cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
    logic cpu_done_q, cpu_done_d, dbg_done_q, dbg_done_d;
    logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic pick_dbg, finish;

    // owner/last_owner encode 1 = dbg, 0 = cpu
    always_comb begin
        pick_dbg = bus.dbg_req & (~bus.cpu_req | ~last_q);
        finish = (state_q == ACCESS & (we_q | RD_LAT == 0)) | (state_q == WAIT & cnt_q == 2'd1);
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        we_d = we_q;
        cnt_d = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d = 1'b0;
        mem_write_d = 1'b0;
        cpu_gnt_d = cpu_gnt_q;
        dbg_gnt_d = dbg_gnt_q;
        cpu_done_d = finish & ~owner_q;
        dbg_done_d = finish & owner_q;
        rdata_d = (finish & ~we_q) ? bus.mem_rdata : rdata_q;
        case (state_q)
            IDLE: if (bus.cpu_req | bus.dbg_req) begin
                owner_d = pick_dbg;
                we_d = pick_dbg ? bus.dbg_we : bus.cpu_we;
                mem_addr_d = pick_dbg ? bus.dbg_addr : bus.cpu_addr;
                mem_wdata_d = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                mem_write_d = we_d;
                mem_read_d = ~we_d;
                cpu_gnt_d = ~pick_dbg;
                dbg_gnt_d = pick_dbg;
                state_d = ACCESS;
            end
            ACCESS: begin
                state_d = finish ? DONE : WAIT;
                cnt_d = 2'(RD_LAT);
            end
            WAIT: begin
                state_d = finish ? DONE : WAIT;
                cnt_d = cnt_q - 2'd1;
            end
            default: begin
                last_d = owner_q;
                cpu_gnt_d = 1'b0;
                dbg_gnt_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= 2'd0;
            owner_q <= 1'b0;
            last_q <= 1'b1;
            we_q <= 1'b0;
            cpu_gnt_q <= 1'b0;
            dbg_gnt_q <= 1'b0;
            cpu_done_q <= 1'b0;
            dbg_done_q <= 1'b0;
            mem_read_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            owner_q <= owner_d;
            last_q <= last_d;
            we_q <= we_d;
            cpu_gnt_q <= cpu_gnt_d;
            dbg_gnt_q <= dbg_gnt_d;
            cpu_done_q <= cpu_done_d;
            dbg_done_q <= dbg_done_d;
            mem_read_q <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.cpu_gnt = cpu_gnt_q;
    assign bus.dbg_gnt = dbg_gnt_q;
    assign bus.cpu_done = cpu_done_q;
    assign bus.dbg_done = dbg_done_q;
    assign bus.mem_read = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with RD_LAT = 1 (index 0), 0 (index 1) and 3 (index 2).
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic [2:0] cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_read, mem_write;
    logic [7:0] rdata [3];
    logic [7:0] mem_addr [3];
    logic [7:0] mem_wdata [3];

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       dbg;
        logic       rd;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] ref_mem [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g == 0 ? 1 : g == 1 ? 0 : 3;
        localparam int I = L == 0 ? 0 : L - 1;
        dmem_arbiter_if bus ();
        logic [7:0] mem [256];
        logic [7:0] dp [4];
        logic [3:0] vp;
        dmem_arbiter #(.RD_LAT(L), .AW(8), .DW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
        assign bus.cpu_req = cpu_req;
        assign bus.cpu_we = cpu_we;
        assign bus.cpu_addr = cpu_addr;
        assign bus.cpu_wdata = cpu_wdata;
        assign bus.dbg_req = dbg_req;
        assign bus.dbg_we = dbg_we;
        assign bus.dbg_addr = dbg_addr;
        assign bus.dbg_wdata = dbg_wdata;
        assign cpu_gnt[g] = bus.cpu_gnt;
        assign cpu_done[g] = bus.cpu_done;
        assign dbg_gnt[g] = bus.dbg_gnt;
        assign dbg_done[g] = bus.dbg_done;
        assign mem_read[g] = bus.mem_read;
        assign mem_write[g] = bus.mem_write;
        assign rdata[g] = bus.rdata;
        assign mem_addr[g] = bus.mem_addr;
        assign mem_wdata[g] = bus.mem_wdata;
        // read data is driven only in the cycle it is valid, garbage otherwise
        always @(posedge clk) begin
            if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
            vp <= reset ? 4'b0 : {vp[2:0], bus.mem_read};
            dp[0] <= mem[bus.mem_addr];
            dp[1] <= dp[0];
            dp[2] <= dp[1];
            dp[3] <= dp[2];
        end
        assign bus.mem_rdata = L == 0 ? (bus.mem_read ? mem[bus.mem_addr] : 8'hEE)
                                      : (vp[I] ? dp[I] : 8'hEE);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] st(input int i);
        return {cpu_gnt[i], cpu_done[i], dbg_gnt[i], dbg_done[i], mem_read[i], mem_write[i]};
    endfunction

    task automatic push(input logic d, input logic w, input logic [7:0] a, input logic [7:0] wd);
        exp_t x;
        if (w) ref_mem[a] = wd;
        x.dbg = d;
        x.rd = ~w;
        x.data = w ? 8'h00 : ref_mem[a];
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (cpu_done[0] | dbg_done[0]) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_done: cpu_done=%b dbg_done=%b, required no done", cpu_done[0], dbg_done[0]);
            end else begin
                mon_e = sb.pop_front();
                if (dbg_done[0] !== mon_e.dbg || cpu_done[0] !== ~mon_e.dbg || (mon_e.rd && rdata[0] !== mon_e.data)) begin
                    miscompares++;
                    $display("FAIL sb_done: cpu_done=%b dbg_done=%b rdata=%h, required dbg=%b rd=%b data=%h",
                             cpu_done[0], dbg_done[0], rdata[0], mon_e.dbg, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (st(i) !== 6'b0 || rdata[i] !== 8'h00 || mem_addr[i] !== 8'h00 || mem_wdata[i] !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: st=%b rdata=%h addr=%h wdata=%h, required all zero", i, st(i), rdata[i], mem_addr[i], mem_wdata[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_write;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 8'hA5;
        push(0, 1, 8'h05, 8'hA5);
        tick;
        vectors++;
        if (st(0) !== 6'b100001 || mem_addr[0] !== 8'h05 || mem_wdata[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL write_access: st=%b addr=%h wdata=%h, required 100001 05 a5", st(0), mem_addr[0], mem_wdata[0]);
        end
        cpu_req = 0;
        tick;
        vectors++;
        if (st(0) !== 6'b110000) begin
            miscompares++;
            $display("FAIL write_done: st=%b, required 110000", st(0));
        end
        tick;
        vectors++;
        if (st(0) !== 6'b000000) begin
            miscompares++;
            $display("FAIL write_idle: st=%b, required 000000", st(0));
        end
    endtask

    task automatic test_read;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h05;
        push(1, 0, 8'h05, 8'h00);
        tick;
        vectors++;
        if (st(0) !== 6'b001010 || mem_addr[0] !== 8'h05) begin
            miscompares++;
            $display("FAIL read_access: st=%b addr=%h, required 001010 05", st(0), mem_addr[0]);
        end
        dbg_req = 0;
        tick;
        vectors++;
        if (st(0) !== 6'b001000 || mem_addr[0] !== 8'h05) begin
            miscompares++;
            $display("FAIL read_wait: st=%b addr=%h, required 001000 05", st(0), mem_addr[0]);
        end
        tick;
        vectors++;
        if (st(0) !== 6'b001100 || rdata[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_done: st=%b rdata=%h, required 001100 a5", st(0), rdata[0]);
        end
        tick;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h07; dbg_wdata = 8'h3C;
        push(1, 1, 8'h07, 8'h3C);
        tick;
        vectors++;
        if (st(0) !== 6'b001001 || mem_addr[0] !== 8'h07) begin
            miscompares++;
            $display("FAIL dbg_write_access: st=%b addr=%h, required 001001 07", st(0), mem_addr[0]);
        end
        dbg_req = 0;
        tick;
        vectors++;
        if (st(0) !== 6'b001100 || rdata[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL rdata_kept_on_write: st=%b rdata=%h, required 001100 a5", st(0), rdata[0]);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int nd = 0;
        int ng = 0;
        logic [3:0] ord = '0;
        logic two = 0, pc = 0, pd = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h11;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h20;
        push(0, 1, 8'h20, 8'h11);
        push(1, 0, 8'h20, 8'h00);
        push(0, 1, 8'h20, 8'h11);
        push(1, 0, 8'h20, 8'h00);
        for (int c = 0; c < 40 && nd < 4; c++) begin
            tick;
            if (cpu_gnt[0] & dbg_gnt[0]) two = 1;
            if (cpu_gnt[0] & ~pc) begin ord = {ord[2:0], 1'b0}; ng++; end
            if (dbg_gnt[0] & ~pd) begin ord = {ord[2:0], 1'b1}; ng++; end
            pc = cpu_gnt[0];
            pd = dbg_gnt[0];
            nd += int'(cpu_done[0]) + int'(dbg_done[0]);
        end
        cpu_req = 0;
        dbg_req = 0;
        vectors++;
        if (nd != 4) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d dones within 40 cycles, required 4", nd);
        end
        vectors++;
        if (ng != 4 || ord !== 4'b0101) begin
            miscompares++;
            $display("FAIL b2b_grant_order: grants=%0d order=%b, required 4 0101 (cpu,dbg,cpu,dbg)", ng, ord);
        end
        vectors++;
        if (two !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_one_gnt: two grants seen high together, required never");
        end
    endtask

    task automatic test_latency;
        int da [3] = '{0, 0, 0};
        int rc [3] = '{0, 0, 0};
        int ed [3] = '{3, 2, 5};
        logic bad [3] = '{0, 0, 0};
        repeat (10) tick;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        push(0, 0, 8'h20, 8'h00);
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (c == 1) cpu_req = 0;
            for (int i = 0; i < 3; i++) begin
                if (mem_read[i]) rc[i]++;
                if (cpu_done[i] && da[i] == 0) da[i] = c;
                if (cpu_gnt[i] && mem_addr[i] !== 8'h20) bad[i] = 1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (da[i] != ed[i]) begin
                miscompares++;
                $display("FAIL lat_done[%0d]: done at cycle %0d, required %0d", i, da[i], ed[i]);
            end
            vectors++;
            if (rc[i] != 1) begin
                miscompares++;
                $display("FAIL lat_read_strobe[%0d]: mem_read high %0d cycles, required 1", i, rc[i]);
            end
            vectors++;
            if (bad[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL lat_addr_stable[%0d]: mem_addr moved while granted, required 20", i);
            end
            vectors++;
            if (rdata[i] !== 8'h11) begin
                miscompares++;
                $display("FAIL lat_rdata[%0d]: rdata=%h, required 11", i, rdata[i]);
            end
        end
    endtask

    task automatic test_reset_abort;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h05;
        tick;
        dbg_req = 0;
        tick;
        vectors++;
        if (st(0) !== 6'b001000) begin
            miscompares++;
            $display("FAIL abort_in_wait: st=%b, required 001000", st(0));
        end
        reset = 1;
        tick;
        vectors++;
        if (st(0) !== 6'b000000 || rdata[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_cleared: st=%b rdata=%h, required 000000 00", st(0), rdata[0]);
        end
        reset = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 8'h5A;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h31; dbg_wdata = 8'h66;
        push(0, 1, 8'h30, 8'h5A);
        push(1, 1, 8'h31, 8'h66);
        tick;
        vectors++;
        if (st(0) !== 6'b100001 || mem_addr[0] !== 8'h30) begin
            miscompares++;
            $display("FAIL abort_tie_cpu_first: st=%b addr=%h, required 100001 30", st(0), mem_addr[0]);
        end
        cpu_req = 0;
        tick;
        tick;
        tick;
        vectors++;
        if (st(0) !== 6'b001001 || mem_addr[0] !== 8'h31 || mem_wdata[0] !== 8'h66) begin
            miscompares++;
            $display("FAIL abort_dbg_next: st=%b addr=%h wdata=%h, required 001001 31 66", st(0), mem_addr[0], mem_wdata[0]);
        end
        dbg_req = 0;
        tick;
        tick;
    endtask

    task automatic test_drop_req;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h40;
        push(0, 1, 8'h40, 8'h77);
        push(1, 0, 8'h40, 8'h00);
        tick;
        vectors++;
        if (st(0) !== 6'b100001 || mem_wdata[0] !== 8'h77) begin
            miscompares++;
            $display("FAIL drop_access: st=%b wdata=%h, required 100001 77", st(0), mem_wdata[0]);
        end
        cpu_req = 0;
        tick;
        vectors++;
        if (st(0) !== 6'b110000) begin
            miscompares++;
            $display("FAIL drop_done: st=%b, required 110000", st(0));
        end
        tick;
        tick;
        vectors++;
        if (st(0) !== 6'b001010 || mem_addr[0] !== 8'h40) begin
            miscompares++;
            $display("FAIL drop_dbg_granted: st=%b addr=%h, required 001010 40", st(0), mem_addr[0]);
        end
        dbg_req = 0;
        tick;
        tick;
        vectors++;
        if (st(0) !== 6'b001100 || rdata[0] !== 8'h77) begin
            miscompares++;
            $display("FAIL drop_dbg_read: st=%b rdata=%h, required 001100 77", st(0), rdata[0]);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_latency;
        test_reset_abort;
        test_drop_req;
        repeat (10) tick;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drained: %0d expected transactions never completed, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbiter and sequencer for the single-port 8-bit data memory.
- Shares the memory between two requesters: the processor core (cpu_*) and a debug/loader port (dbg_*).
- Accepts one request at a time, round-robin on ties, and drives the memory read/write strobes with a configurable read latency.
- Returns read data plus a one-cycle done pulse to the granted requester.

Parameters:
- RD_LAT, 1: cycles from the mem_read assertion cycle to the cycle mem_rdata is valid. Legal range 0..3; 0 means combinational read in the same cycle.
- AW, 8: address width.
- DW, 8: data width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  core requests an access
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  core address
- cpu_wdata  in  DW  core write data
- cpu_gnt  out  1  core owns the memory (level)
- cpu_done  out  1  core access complete (1-cycle pulse)
- dbg_req  in  1  debug requests an access
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_gnt  out  1  debug owns the memory (level)
- dbg_done  out  1  debug access complete (1-cycle pulse)
- rdata  out  DW  read data of the last completed read
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- All outputs are registered.
- Reset (synchronous) forces, effective next edge:
  - state=IDLE, last_owner=DBG (cpu wins the first tie).
  - all gnt, done, mem_read and mem_write = 0; rdata, mem_addr, mem_wdata = 0.
- Reset mid-transaction aborts it: strobes drop, no done pulse, memory contents undefined for an aborted write only if reset coincides with the mem_write cycle.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Single request: that requester wins.
  - Both requests: the requester not equal to last_owner wins.
  - The winner's we/addr/wdata are latched and owner is recorded; next state ACCESS.
  - No request: remain in IDLE.
- ACCESS (1 cycle):
  - owner's gnt=1; mem_addr and mem_wdata come from the latched values.
  - Write: mem_write=1, next state DONE.
  - Read: mem_read=1.
    - RD_LAT=0: capture mem_rdata into rdata this cycle, next state DONE.
    - RD_LAT>0: load wait counter with RD_LAT, next state WAIT.
- WAIT:
  - gnt held; mem_read=0; counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata into rdata and go to DONE.
  - WAIT therefore lasts exactly RD_LAT cycles.
- DONE (1 cycle):
  - owner's done=1, gnt=1.
  - last_owner is updated to owner; next state IDLE.
- gnt falls in the cycle after DONE.
- Strobe rules:
  - mem_read and mem_write are never high together and each is high for exactly one cycle per transaction.
  - mem_addr holds its value through WAIT.
- rdata is unchanged by writes and by aborted reads.
- Latency from req seen in IDLE at cycle T:
  - gnt rises at T+1.
  - write done at T+2.
  - read done at T+2+RD_LAT.
  - Minimum request-to-request spacing is 3+RD_LAT cycles (read) or 3 cycles (write), including the IDLE cycle.
- Requesters must keep req, we, addr and wdata stable until gnt. Inputs are ignored once latched.
- Requesters drop req in the done cycle; req still high in the following IDLE is a new request.
- Dropping req after acceptance does not cancel the transaction; done still pulses.
- A non-owner's req is held off (its gnt=0) until the next IDLE. No request is ever lost while it stays asserted.
- Never more than one gnt high.

Test Plan:
- Reset, then cpu_req=1, cpu_we=1, addr=0x05, wdata=0xA5 at cycle 0 -> cpu_gnt=1 and mem_write=1 with mem_addr=0x05, mem_wdata=0xA5 at cycle 1; cpu_done=1 at cycle 2; dbg signals stay 0.
- RD_LAT=1, memory preloaded [0x05]=0xA5; dbg read of 0x05 -> mem_read one cycle, dbg_done 2 cycles later, rdata=0xA5; rdata unchanged by a following write.
- cpu_req and dbg_req both held high for 4 transactions -> grants alternate cpu, dbg, cpu, dbg; never two gnts high; one done per transaction.
- RD_LAT=0 and RD_LAT=3 builds, cpu read -> done at T+2 and T+5 respectively; mem_read high exactly one cycle; mem_addr stable through WAIT.
- Assert reset during WAIT of a dbg read -> next cycle all gnt, done and strobes are 0, state IDLE, no dbg_done; a subsequent cpu_req wins the tie against dbg_req (last_owner=DBG).
- cpu drops cpu_req in the ACCESS cycle of its write -> write still performed and cpu_done still pulses; pending dbg_req is granted in the following IDLE.
